stream_cmd_gen: RTL and testbench
=================================

# stream_cmd_gen

Upstream command sequencer for the XOR stream unit. It accepts one job descriptor (base address, count, key) and emits two independent command streams: an address stream for the memory-read port (`cmdA`) and a data stream for the XOR operand port (`cmdB`). Each stream has its own counter, so either side may stall independently. A done pulse is issued once both streams have fully drained.

## Interface
Parameters:
- ADDR_WIDTH, 8: width of cmdA address payload; addresses wrap modulo 2^ADDR_WIDTH
- DATA_WIDTH, 32: width of key and cmdB payload
- COUNT_WIDTH, 9: width of job count; maximum job length 2^(COUNT_WIDTH-1) = 256

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- io_start_valid  in  1  job descriptor valid
- io_start_ready  out  1  job accepted when valid && ready
- io_start_payload_base  in  ADDR_WIDTH  first read address
- io_start_payload_count  in  COUNT_WIDTH  number of commands per stream
- io_start_payload_key  in  DATA_WIDTH  cmdB seed value
- io_cmdA_valid  out  1  address command valid
- io_cmdA_ready  in  1  address command accepted
- io_cmdA_payload  out  ADDR_WIDTH  read address
- io_cmdB_valid  out  1  operand command valid
- io_cmdB_ready  in  1  operand command accepted
- io_cmdB_payload  out  DATA_WIDTH  XOR operand
- io_busy  out  1  job in progress (state != IDLE)
- io_done  out  1  one-cycle pulse at job completion

## Operation
- States: IDLE, RUN, DONE.
- IDLE: io_start_ready = 1. On start fire, the block latches base into aAddr and key into keyReg, and sets bIdx = 0.
  - effCount = 256 if count[COUNT_WIDTH-1] is set, else count. Any value ≥ 256 saturates to 256.
  - aRem = bRem = effCount.
  - If effCount = 0, next state is DONE; otherwise RUN.
- RUN:
  - io_cmdA_valid = (aRem != 0); io_cmdA_payload = aAddr.
  - On cmdA fire: aRem decrements; aAddr increments modulo 2^ADDR_WIDTH (0xFF wraps to 0x00).
  - io_cmdB_valid = (bRem != 0); io_cmdB_payload = keyReg + bIdx, modulo 2^DATA_WIDTH (0xFFFFFFFF + 1 wraps to 0).
  - On cmdB fire: bRem decrements; bIdx increments.
  - The two streams are fully independent. Simultaneous fires in one cycle are legal and both counters advance.
  - When aRem and bRem are both 0 after a cycle's updates, next state is DONE. The last fires may occur in the same cycle or in different cycles.
- DONE: io_done = 1 for exactly one cycle, then IDLE unconditionally.
- io_start_ready = 0 in RUN and DONE. A start presented then is held off, not dropped.
- Valid/payload rules:
  - Valids and payloads are derived only from registers; there is no combinational path from any ready to any valid or payload.
  - Once valid is asserted, it and its payload hold stable until fire.
- Reset, asynchronous, any state: state = IDLE and all counters cleared.
  - Reset values: io_cmdA_valid = 0, io_cmdB_valid = 0, io_done = 0, io_busy = 0, io_start_ready = 1 (after reset deasserts), payloads = 0.
  - A job interrupted by reset is abandoned; nothing resumes.

## Timing
- Start fire at edge N: state RUN from N. Both valids are high in cycle N+1, i.e. first command available one cycle after acceptance.
- Throughput: one command per stream per cycle with ready held high. A job of count C with both readies high completes its last fire in cycle N+C.
- Last outstanding fire at edge M: io_done high during cycle M+1. State IDLE and io_start_ready = 1 in cycle M+2.
- count = 0: io_done high in cycle N+1; no valid is asserted at any point.
- Minimum start-to-start spacing: C + 2 cycles.

## Test plan
- Basic job, both readies held high: base = 0x10, count = 4, key = 0xA0000000.
  - cmdA sequence: 0x10, 0x11, 0x12, 0x13 in cycles N+1..N+4.
  - cmdB sequence: 0xA0000000..0xA0000003 in the same cycles.
  - io_done at N+5; io_start_ready at N+6.
- Address and key wrap: base = 0xFE, count = 3, key = 0xFFFFFFFF.
  - cmdA: 0xFE, 0xFF, 0x00.
  - cmdB: 0xFFFFFFFF, 0x00000000, 0x00000001.
- Independent stalls: count = 3, cmdA_ready high, cmdB_ready low for 5 cycles then high.
  - cmdA drains in 3 cycles; cmdB_valid stays high with payload = key held stable.
  - io_done occurs one cycle after the 3rd cmdB fire, never earlier.
- Saturation: count = 0x1FF.
  - Exactly 256 fires per stream; cmdA covers 256 addresses returning to base.
  - Then a single io_done pulse.
- count = 0, then a second start with count = 1 presented back-to-back.
  - First job: io_done at N+1, no valids at any point.
  - Second start: held off (ready = 0) until N+2, then accepted.
- Reset mid-job: count = 10, reset asserted after 4 fires.
  - Valids, busy and done drop asynchronously the same cycle.
  - After release, start_ready = 1 and a new job starts from its own base.

Source files
------------

// File: rtl/stream_cmd_gen_if.sv
// stream_cmd_gen_if: job descriptor input, address/operand command streams and job status.
interface stream_cmd_gen_if #(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 32,
   parameter int COUNT_WIDTH = 9
);
   logic                   start_valid;
   logic                   start_ready;
   logic [ADDR_WIDTH-1:0]  start_base;
   logic [COUNT_WIDTH-1:0] start_count;
   logic [DATA_WIDTH-1:0]  start_key;
   logic                   cmd_a_valid;
   logic                   cmd_a_ready;
   logic [ADDR_WIDTH-1:0]  cmd_a_payload;
   logic                   cmd_b_valid;
   logic                   cmd_b_ready;
   logic [DATA_WIDTH-1:0]  cmd_b_payload;
   logic                   busy;
   logic                   done;
   modport master (
      input  start_valid, start_base, start_count, start_key, cmd_a_ready, cmd_b_ready,
      output start_ready, cmd_a_valid, cmd_a_payload, cmd_b_valid, cmd_b_payload, busy, done
   );
   modport slave (
      output start_valid, start_base, start_count, start_key, cmd_a_ready, cmd_b_ready,
      input  start_ready, cmd_a_valid, cmd_a_payload, cmd_b_valid, cmd_b_payload, busy, done
   );
endinterface

// File: rtl/stream_cmd_gen.sv
// stream_cmd_gen: turns one job descriptor into independent address and operand command streams.
module stream_cmd_gen #(
   parameter int ADDR_WIDTH  = 8,
   parameter int DATA_WIDTH  = 32,
   parameter int COUNT_WIDTH = 9
) (
   input logic clk,
   input logic reset,
   stream_cmd_gen_if.master io
);
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;
   localparam logic [COUNT_WIDTH-1:0] MAX_COUNT = {1'b1, {(COUNT_WIDTH-1){1'b0}}};
   logic [1:0]             state_q, state_d;
   logic [ADDR_WIDTH-1:0]  a_addr_q, a_addr_d;
   logic [DATA_WIDTH-1:0]  key_q, key_d;
   logic [COUNT_WIDTH-1:0] a_rem_q, a_rem_d, b_rem_q, b_rem_d, b_idx_q, b_idx_d;
   logic [COUNT_WIDTH-1:0] eff_count;
   logic                   start_fire, a_fire, b_fire;
   // Outputs depend only on registers, so no ready-to-valid combinational path exists.
   assign io.start_ready   = state_q == IDLE;
   assign io.busy          = state_q != IDLE;
   assign io.done          = state_q == DONE;
   assign io.cmd_a_valid   = state_q == RUN && a_rem_q != '0;
   assign io.cmd_b_valid   = state_q == RUN && b_rem_q != '0;
   assign io.cmd_a_payload = a_addr_q;
   assign io.cmd_b_payload = key_q + DATA_WIDTH'(b_idx_q);
   always_comb begin
      start_fire = io.start_valid && io.start_ready;
      a_fire     = io.cmd_a_valid && io.cmd_a_ready;
      b_fire     = io.cmd_b_valid && io.cmd_b_ready;
      eff_count  = io.start_count[COUNT_WIDTH-1] ? MAX_COUNT : io.start_count;
      a_addr_d   = start_fire ? io.start_base : a_addr_q + ADDR_WIDTH'(a_fire);
      key_d      = start_fire ? io.start_key : key_q;
      a_rem_d    = start_fire ? eff_count : a_rem_q - COUNT_WIDTH'(a_fire);
      b_rem_d    = start_fire ? eff_count : b_rem_q - COUNT_WIDTH'(b_fire);
      b_idx_d    = start_fire ? '0 : b_idx_q + COUNT_WIDTH'(b_fire);
      state_d    = start_fire ? (eff_count == '0 ? DONE : RUN) :
                   state_q == RUN ? (a_rem_d == '0 && b_rem_d == '0 ? DONE : RUN) : IDLE;
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         state_q  <= IDLE;
         a_addr_q <= '0;
         key_q    <= '0;
         a_rem_q  <= '0;
         b_rem_q  <= '0;
         b_idx_q  <= '0;
      end else begin
         state_q  <= state_d;
         a_addr_q <= a_addr_d;
         key_q    <= key_d;
         a_rem_q  <= a_rem_d;
         b_rem_q  <= b_rem_d;
         b_idx_q  <= b_idx_d;
      end
endmodule

// File: tb/tb_stream_cmd_gen.sv
// tb_stream_cmd_gen: directed and randomized jobs checked against an index-counting stream model.
module tb_stream_cmd_gen;
   logic clk = 1'b0;
   logic reset;
   int   n_cmp = 0;
   int   n_err = 0;
   always #5 clk = ~clk;
   stream_cmd_gen_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .COUNT_WIDTH(9)) io ();
   stream_cmd_gen #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .COUNT_WIDTH(9)) dut (
      .clk(clk), .reset(reset), .io(io.master)
   );
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   // Model: stream k must present base+k / key+k until its k-th accepted fire; done follows the last fire.
   task automatic run_job(input logic [7:0] base, input logic [8:0] count, input logic [31:0] key,
                          input int pa, input int pb, input int b_stall);
      int eff, na, nb, cyc;
      bit ra, rb;
      eff = count >= 9'd256 ? 256 : int'(count);
      io.start_valid = 1'b1;
      io.start_base  = base;
      io.start_count = count;
      io.start_key   = key;
      chk("start_ready_idle", io.start_ready, 1);
      @(posedge clk);
      @(negedge clk);
      io.start_valid = 1'b0;
      na = 0;
      nb = 0;
      cyc = 0;
      while ((na < eff || nb < eff) && cyc < 2000) begin
         chk("a_valid", io.cmd_a_valid, na < eff);
         if (na < eff) chk("a_payload", io.cmd_a_payload, 8'(base + na));
         chk("b_valid", io.cmd_b_valid, nb < eff);
         if (nb < eff) chk("b_payload", io.cmd_b_payload, 32'(key + nb));
         chk("done_run", io.done, 0);
         chk("busy_run", io.busy, 1);
         chk("start_ready_run", io.start_ready, 0);
         ra = ($urandom % 100) < pa;
         rb = cyc >= b_stall && ($urandom % 100) < pb;
         io.cmd_a_ready = ra;
         io.cmd_b_ready = rb;
         @(posedge clk);
         if (ra && na < eff) na++;
         if (rb && nb < eff) nb++;
         @(negedge clk);
         cyc++;
      end
      chk("job_timeout", cyc < 2000, 1);
      chk("done_pulse", io.done, 1);
      chk("a_valid_done", io.cmd_a_valid, 0);
      chk("b_valid_done", io.cmd_b_valid, 0);
      chk("start_ready_done", io.start_ready, 0);
      @(negedge clk);
      chk("done_clear", io.done, 0);
      chk("busy_idle", io.busy, 0);
      chk("start_ready_after", io.start_ready, 1);
   endtask
   initial begin
      reset = 1'b1;
      io.start_valid = 1'b0;
      io.start_base  = '0;
      io.start_count = '0;
      io.start_key   = '0;
      io.cmd_a_ready = 1'b0;
      io.cmd_b_ready = 1'b0;
      @(negedge clk);
      chk("rst_a_valid", io.cmd_a_valid, 0);
      chk("rst_b_valid", io.cmd_b_valid, 0);
      chk("rst_done", io.done, 0);
      chk("rst_busy", io.busy, 0);
      chk("rst_start_ready", io.start_ready, 1);
      chk("rst_a_payload", io.cmd_a_payload, 0);
      chk("rst_b_payload", io.cmd_b_payload, 0);
      reset = 1'b0;
      run_job(8'h10, 9'd4, 32'hA000_0000, 100, 100, 0);
      run_job(8'hFE, 9'd3, 32'hFFFF_FFFF, 100, 100, 0);
      run_job(8'h33, 9'd3, 32'h1234_5678, 100, 100, 5);
      run_job(8'h80, 9'h1FF, 32'hDEAD_BEEF, 100, 100, 0);
      // count = 0 job followed by a back-to-back start that must be held off for one cycle
      io.cmd_a_ready = 1'b1;
      io.cmd_b_ready = 1'b1;
      io.start_valid = 1'b1;
      io.start_base  = 8'h21;
      io.start_count = 9'd0;
      io.start_key   = 32'h0000_0F00;
      chk("z_start_ready", io.start_ready, 1);
      @(posedge clk);
      @(negedge clk);
      io.start_base  = 8'h5A;
      io.start_count = 9'd1;
      io.start_key   = 32'hCAFE_0000;
      chk("z_done", io.done, 1);
      chk("z_a_valid", io.cmd_a_valid, 0);
      chk("z_b_valid", io.cmd_b_valid, 0);
      chk("z_held_off", io.start_ready, 0);
      @(posedge clk);
      @(negedge clk);
      chk("z_done_clear", io.done, 0);
      chk("z_a_valid_idle", io.cmd_a_valid, 0);
      chk("z_ready_again", io.start_ready, 1);
      @(posedge clk);
      @(negedge clk);
      io.start_valid = 1'b0;
      chk("z2_a_valid", io.cmd_a_valid, 1);
      chk("z2_a_payload", io.cmd_a_payload, 8'h5A);
      chk("z2_b_valid", io.cmd_b_valid, 1);
      chk("z2_b_payload", io.cmd_b_payload, 32'hCAFE_0000);
      @(negedge clk);
      chk("z2_done", io.done, 1);
      chk("z2_a_valid_done", io.cmd_a_valid, 0);
      @(negedge clk);
      chk("z2_start_ready", io.start_ready, 1);
      // asynchronous reset in the middle of a job
      io.start_valid = 1'b1;
      io.start_base  = 8'h40;
      io.start_count = 9'd10;
      io.start_key   = 32'h0000_0055;
      @(posedge clk);
      @(negedge clk);
      io.start_valid = 1'b0;
      repeat (4) @(posedge clk);
      #1;
      chk("mid_busy", io.busy, 1);
      chk("mid_a_payload", io.cmd_a_payload, 8'h44);
      #1 reset = 1'b1;
      #1;
      chk("ar_a_valid", io.cmd_a_valid, 0);
      chk("ar_b_valid", io.cmd_b_valid, 0);
      chk("ar_busy", io.busy, 0);
      chk("ar_done", io.done, 0);
      chk("ar_start_ready", io.start_ready, 1);
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      chk("ar_ready_release", io.start_ready, 1);
      chk("ar_a_valid_release", io.cmd_a_valid, 0);
      run_job(8'h90, 9'd5, 32'h0BAD_F00D, 100, 100, 0);
      repeat (10) run_job(8'($urandom), 9'($urandom_range(0, 511)), $urandom,
                          int'($urandom_range(20, 100)), int'($urandom_range(20, 100)),
                          int'($urandom_range(0, 4)));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
